// File: rtl/rr_grant_sched8_pkg.sv
// Shared constants and types for the rr_grant_sched8 round-robin scheduler.
//   N_REQ  : number of requesters (8)
//   IDX_W  : width of the owner select index (3)
//   HOLD_W : width of the optional watchdog hold counter
//   state_e: scheduler state (IDLE / BUSY)
package rr_grant_sched8_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/grant_dec3to8.sv
// One-hot decoder with enable: turns the registered owner index and grant
// valid into the 8-bit one-hot grant vector. Purely combinational.
//   idx   in  [IDX_W-1:0] owner index
//   en    in  grant valid
//   grant out [N_REQ-1:0] one-hot grant, all zero when en=0
module grant_dec3to8
  import rr_grant_sched8_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign grant[i] = en && (idx == IDX_W'(i));
  end

endmodule

// File: rtl/rr_grant_sched8.sv
// Round-robin scheduler sharing one 8-way one-hot-selected resource.
// Picks a winner from req starting at a rotating pointer, holds the grant
// until the owner releases it or drops its request, and always inserts one
// idle cycle between consecutive grants.
//   clk        in  clock, rising edge
//   rst_n      in  synchronous active-low reset
//   req        in  [7:0] level request per requester
//   release_in in  [7:0] release pulse per requester (only owner's bit used);
//                  named release_in because "release" is a reserved word
//   sel_idx    out [2:0] current owner index (holds value while idle)
//   sel_en     out grant valid
//   grant      out [7:0] one-hot grant decoded from sel_idx/sel_en
//   timeout    out watchdog revoke pulse (constant 0 without the watchdog)
// Optional feature: define RR_GRANT_SCHED8_WDOG_EN to build in the hold
// watchdog, which revokes a grant held for MAX_HOLD cycles.
module rr_grant_sched8
  import rr_grant_sched8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] release_in,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_en,
  output logic [N_REQ-1:0] grant,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_grant_sched8: MAX_HOLD must be in 2..255");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;

  // Priority search: first asserted req at ptr, ptr+1, ... wrapping mod 8.
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && req[ptr_q + IDX_W'(i)]) begin
        win_vld = 1'b1;
        win_idx = ptr_q + IDX_W'(i);
      end
    end
  end

  logic owner_done;
  assign owner_done = release_in[sel_idx_q] || !req[sel_idx_q];

`ifdef RR_GRANT_SCHED8_WDOG_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_idx_d = sel_idx_q;
`ifdef RR_GRANT_SCHED8_WDOG_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d   = BUSY;
          sel_idx_d = win_idx;
          ptr_d     = win_idx + IDX_W'(1);
`ifdef RR_GRANT_SCHED8_WDOG_EN
          hold_cnt_d = '0;
`endif
        end
      end
      BUSY: begin
        // A normal release wins over a coincident expiry (no timeout pulse).
        if (owner_done) begin
          state_d = IDLE;
`ifdef RR_GRANT_SCHED8_WDOG_EN
        end else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_idx_q <= '0;
`ifdef RR_GRANT_SCHED8_WDOG_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_idx_q <= sel_idx_d;
`ifdef RR_GRANT_SCHED8_WDOG_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign sel_idx = sel_idx_q;
  assign sel_en  = (state_q == BUSY);

`ifdef RR_GRANT_SCHED8_WDOG_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  grant_dec3to8 u_dec (
    .idx   (sel_idx_q),
    .en    (sel_en),
    .grant (grant)
  );

endmodule

// File: tb/tb_rr_grant_sched8.sv
module tb_rr_grant_sched8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] release_in;
  logic [2:0] sel_idx;
  logic       sel_en;
  logic [7:0] grant;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_grant_sched8 #(.MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .release_in (release_in),
    .sel_idx    (sel_idx),
    .sel_en     (sel_en),
    .grant      (grant),
    .timeout    (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are stable 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_g;
    int bad;
    rst_n = 1'b0; req = 8'hFF; release_in = 8'h00;

    // reset hold for 3 cycles with all requests high
    repeat (3) step();
    chk("rst_grant", grant, 8'h00);
    chk("rst_en", sel_en, 1'b0);
    chk("rst_idx", sel_idx, 3'd0);
    chk("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    step();
    chk("first_grant", grant, 8'h01);
    chk("first_idx", sel_idx, 3'd0);

    // rotation with release one cycle after each grant
    exp_g = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      release_in = exp_g;
      step();
      release_in = 8'h00;
      chk("rot_dead", grant, 8'h00);
      step();
      exp_g = 8'h01 << (k % 8);
      chk("rot_grant", grant, exp_g);
    end

    // owner 0 drops; then get ptr=3 via a grant to index 2
    req = 8'h00;
    step();
    chk("drop_idle", grant, 8'h00);
    req = 8'h04;
    step();
    chk("g2_for_ptr", grant, 8'h04);
    req = 8'h00;
    step();
    // pointer skip: ptr=3, req=05 -> index 0
    req = 8'h05;
    step();
    chk("skip_grant", grant, 8'h01);
    chk("skip_idx", sel_idx, 3'd0);
    req = 8'h04;
    step();
    chk("skip_dead", grant, 8'h00);
    step();
    chk("skip_next", grant, 8'h04);

    // spurious release, then owner drop
    release_in = 8'h10;
    step();
    release_in = 8'h00;
    chk("spur_rel", grant, 8'h04);
    req = 8'h00;
    step();
    chk("owner_drop", grant, 8'h00);
    chk("owner_drop_en", sel_en, 1'b0);

    // release seen while idle is ignored; then reset mid-grant with owner 5
    release_in = 8'h20; req = 8'h20;
    step();
    release_in = 8'h00;
    chk("own5_grant", grant, 8'h20);
    chk("own5_idx", sel_idx, 3'd5);
    rst_n = 1'b0;
    step();
    chk("midrst_grant", grant, 8'h00);
    chk("midrst_en", sel_en, 1'b0);
    rst_n = 1'b1; req = 8'hFF;
    step();
    chk("post_rst_ptr0", grant, 8'h01);
    req = 8'h00;
    step();
    chk("post_rst_idle", grant, 8'h00);

    // watchdog: owner 6 never releases
    req = 8'h40;
    step();
    chk("wd_grant", grant, 8'h40);
`ifdef RR_GRANT_SCHED8_WDOG_EN
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("wd_hold", grant, 8'h40);
      chk("wd_no_to", timeout, 1'b0);
    end
    step();
    chk("wd_revoke", grant, 8'h00);
    chk("wd_timeout", timeout, 1'b1);
    step();
    chk("wd_to_pulse", timeout, 1'b0);
    chk("wd_regrant", grant, 8'h40);
    // release coincides with expiry: normal release, no timeout
    repeat (3) step();
    chk("wd_late_hold", grant, 8'h40);
    release_in = 8'h40;
    step();
    release_in = 8'h00;
    chk("wd_rel_wins", grant, 8'h00);
    chk("wd_rel_no_to", timeout, 1'b0);
`else
    bad = 0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (grant !== 8'h40 || timeout !== 1'b0) bad++;
    end
    chk("hold_persist_bad_cycles", bad, 0);
    req = 8'h00;
    step();
    chk("hold_drop", grant, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
